// File: rtl/vga_rect_engine.sv
// -----------------------------------------------------------------------------
// vga_rect_engine
// Pixel-generation engine feeding the VGA adapter. On a start request it draws
// a filled rectangle, a rectangle outline or clears the whole screen, emitting
// one pixel per non-stalled cycle in raster order and clipping to the screen.
//
// Ports
//   CLOCK_50   in   clock, all state on the rising edge
//   Resetn     in   asynchronous active-low reset
//   start      in   draw request, sampled only while idle
//   mode       in   00 fill, 01 outline, 10 clear screen, 11 fill
//   x0, y0     in   top-left corner of the rectangle
//   w, h       in   rectangle size in pixels (0 = nothing to draw)
//   color      in   draw colour
//   stall      in   hold the current pixel, no plot this cycle
//   VGA_X      out  pixel x to adapter
//   VGA_Y      out  pixel y to adapter
//   VGA_COLOR  out  pixel colour to adapter
//   plot       out  write strobe for the presented pixel
//   busy       out  operation in progress
//   done       out  one-cycle completion pulse
// -----------------------------------------------------------------------------
module vga_rect_engine #(
    parameter int unsigned H_RES       = 640,
    parameter int unsigned V_RES       = 480,
    parameter int unsigned XW          = 10,
    parameter int unsigned YW          = 9,
    parameter int unsigned COLOR_DEPTH = 9
) (
    input  logic                   CLOCK_50,
    input  logic                   Resetn,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [XW-1:0]          x0,
    input  logic [YW-1:0]          y0,
    input  logic [XW:0]            w,
    input  logic [YW:0]            h,
    input  logic [COLOR_DEPTH-1:0] color,
    input  logic                   stall,
    output logic [XW-1:0]          VGA_X,
    output logic [YW-1:0]          VGA_Y,
    output logic [COLOR_DEPTH-1:0] VGA_COLOR,
    output logic                   plot,
    output logic                   busy,
    output logic                   done
);

    // Sum widths carry one spare bit beyond x0+w so an oversized w cannot wrap
    // around and defeat the clip.
    localparam int unsigned SXW = XW + 2;
    localparam int unsigned SYW = YW + 2;

    localparam logic [1:0] MODE_OUTLINE = 2'b01;
    localparam logic [1:0] MODE_CLEAR   = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DRAW = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Request latched at acceptance
    logic [1:0]             r_mode;
    logic [XW-1:0]          r_x0;
    logic [YW-1:0]          r_y0;
    logic [XW:0]            r_w;
    logic [YW:0]            r_h;

    // Clipped drawing window and raster cursor
    logic [XW-1:0]          r_xs;
    logic [XW-1:0]          r_xe;
    logic [YW-1:0]          r_ys;
    logic [YW-1:0]          r_ye;
    logic [XW-1:0]          r_cx;
    logic [YW-1:0]          r_cy;

    // Registered outputs
    logic [XW-1:0]          r_vga_x;
    logic [YW-1:0]          r_vga_y;
    logic [COLOR_DEPTH-1:0] r_vga_color;
    logic                   r_plot;
    logic                   r_busy;
    logic                   r_done;

    // Next values for the registered outputs
    logic [XW-1:0]          w_vga_x_nxt;
    logic [YW-1:0]          w_vga_y_nxt;
    logic [COLOR_DEPTH-1:0] w_vga_color_nxt;
    logic                   w_plot_nxt;
    logic                   w_busy_nxt;
    logic                   w_done_nxt;

    // Effective geometry: clear mode substitutes the full screen
    logic                   w_clear;
    logic                   w_outline;
    logic [XW-1:0]          w_x0_eff;
    logic [YW-1:0]          w_y0_eff;
    logic [XW:0]            w_w_eff;
    logic [YW:0]            w_h_eff;
    logic [SXW-1:0]         w_xsum;
    logic [SYW-1:0]         w_ysum;
    logic [XW-1:0]          w_xe;
    logic [YW-1:0]          w_ye;
    logic                   w_empty;

    // Cursor status in DRAW
    logic                   w_last;
    logic                   w_row_end;
    logic                   w_on_edge;

    assign w_clear   = (r_mode == MODE_CLEAR);
    assign w_outline = (r_mode == MODE_OUTLINE);

    assign w_x0_eff = w_clear ? '0 : r_x0;
    assign w_y0_eff = w_clear ? '0 : r_y0;
    assign w_w_eff  = w_clear ? (XW+1)'(H_RES) : r_w;
    assign w_h_eff  = w_clear ? (YW+1)'(V_RES) : r_h;

    // Inclusive far corner, clamped to the last visible pixel
    assign w_xsum = SXW'(w_x0_eff) + SXW'(w_w_eff) - SXW'(1);
    assign w_ysum = SYW'(w_y0_eff) + SYW'(w_h_eff) - SYW'(1);
    assign w_xe   = (w_xsum > SXW'(H_RES - 1)) ? XW'(H_RES - 1) : XW'(w_xsum);
    assign w_ye   = (w_ysum > SYW'(V_RES - 1)) ? YW'(V_RES - 1) : YW'(w_ysum);

    // Nothing visible: zero size or origin off-screen
    assign w_empty = (w_w_eff == '0) || (w_h_eff == '0) ||
                     (SXW'(w_x0_eff) >= SXW'(H_RES)) ||
                     (SYW'(w_y0_eff) >= SYW'(V_RES));

    assign w_row_end = (r_cx == r_xe);
    assign w_last    = w_row_end && (r_cy == r_ye);
    assign w_on_edge = (r_cx == r_xs) || (r_cx == r_xe) ||
                       (r_cy == r_ys) || (r_cy == r_ye);

    // State register
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_state_nxt = w_empty ? S_DONE : S_DRAW;
            end
            S_DRAW: begin
                if (!stall && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Output logic: next values for the registered adapter-side outputs
    always_comb begin
        w_plot_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_busy_nxt      = r_busy;
        w_vga_x_nxt     = r_vga_x;
        w_vga_y_nxt     = r_vga_y;
        w_vga_color_nxt = r_vga_color;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = start;
                if (start) begin
                    w_vga_color_nxt = color;
                end
            end
            S_LOAD: begin
                w_busy_nxt = 1'b1;
            end
            S_DRAW: begin
                w_busy_nxt = 1'b1;
                if (!stall) begin
                    // Outline interior cells consume a cycle without a strobe
                    w_plot_nxt = w_outline ? w_on_edge : 1'b1;
                end
                // Coordinates only move with a real plot, otherwise hold
                if (w_plot_nxt) begin
                    w_vga_x_nxt = r_cx;
                    w_vga_y_nxt = r_cy;
                end
            end
            S_DONE: begin
                w_busy_nxt = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_color <= '0;
            r_plot      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vga_x     <= w_vga_x_nxt;
            r_vga_y     <= w_vga_y_nxt;
            r_vga_color <= w_vga_color_nxt;
            r_plot      <= w_plot_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    // Request capture, window setup and raster cursor
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            r_mode <= '0;
            r_x0   <= '0;
            r_y0   <= '0;
            r_w    <= '0;
            r_h    <= '0;
            r_xs   <= '0;
            r_xe   <= '0;
            r_ys   <= '0;
            r_ye   <= '0;
            r_cx   <= '0;
            r_cy   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_mode <= mode;
                        r_x0   <= x0;
                        r_y0   <= y0;
                        r_w    <= w;
                        r_h    <= h;
                    end
                end
                S_LOAD: begin
                    r_xs <= w_x0_eff;
                    r_ys <= w_y0_eff;
                    r_xe <= w_xe;
                    r_ye <= w_ye;
                    r_cx <= w_x0_eff;
                    r_cy <= w_y0_eff;
                end
                S_DRAW: begin
                    // Cursor overrun past the last pixel is harmless: FSM leaves DRAW
                    if (!stall) begin
                        if (w_row_end) begin
                            r_cx <= r_xs;
                            r_cy <= r_cy + YW'(1);
                        end else begin
                            r_cx <= r_cx + XW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign VGA_X     = r_vga_x;
    assign VGA_Y     = r_vga_y;
    assign VGA_COLOR = r_vga_color;
    assign plot      = r_plot;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_vga_rect_engine.sv
// -----------------------------------------------------------------------------
// tb_vga_rect_engine
// Self-checking bench for vga_rect_engine at 160x120. Expected pixels are
// queued before each draw; a negedge monitor pops and compares every plotted
// pixel. Each task checks latency, pixel counts and handshake timing.
// -----------------------------------------------------------------------------
module tb_vga_rect_engine;

    localparam int H  = 160;
    localparam int V  = 120;
    localparam int XW = 8;
    localparam int YW = 7;
    localparam int CD = 9;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [1:0]    mode;
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW:0]   w;
    logic [YW:0]   h;
    logic [CD-1:0] color;
    logic          stall;
    logic [XW-1:0] vga_x;
    logic [YW-1:0] vga_y;
    logic [CD-1:0] vga_color;
    logic          plot;
    logic          busy;
    logic          done;

    int   total = 0;
    int   bad   = 0;
    pix_t exp_q[$];
    pix_t mon_e;

    vga_rect_engine #(
        .H_RES(H), .V_RES(V), .XW(XW), .YW(YW), .COLOR_DEPTH(CD)
    ) dut (
        .CLOCK_50 (clk),
        .Resetn   (rst_n),
        .start    (start),
        .mode     (mode),
        .x0       (x0),
        .y0       (y0),
        .w        (w),
        .h        (h),
        .color    (color),
        .stall    (stall),
        .VGA_X    (vga_x),
        .VGA_Y    (vga_y),
        .VGA_COLOR(vga_color),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // Scoreboard monitor: every plotted pixel must match the queue head
    always @(negedge clk) begin
        if (plot === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_plot: got (%0d,%0d) want no plot", vga_x, vga_y);
            end else begin
                mon_e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_color} !== {XW'(mon_e.x), YW'(mon_e.y), CD'(mon_e.c)}) begin
                    bad++;
                    $display("FAIL pixel: got (%0d,%0d,%h) want (%0d,%0d,%h)",
                             vga_x, vga_y, vga_color, mon_e.x, mon_e.y, mon_e.c);
                end
            end
        end
    end

    // Reference model of the clipped raster scan
    task automatic push_rect(input int m, input int ix, input int iy,
                             input int iw, input int ih, input int ic);
        int xs, ys, ww, hh, xe, ye;
        xs = ix; ys = iy; ww = iw; hh = ih;
        if (m == 2) begin
            xs = 0; ys = 0; ww = H; hh = V;
        end
        if (ww == 0 || hh == 0 || xs >= H || ys >= V) return;
        xe = xs + ww - 1;
        ye = ys + hh - 1;
        if (xe > H - 1) xe = H - 1;
        if (ye > V - 1) ye = V - 1;
        for (int yy = ys; yy <= ye; yy++) begin
            for (int xx = xs; xx <= xe; xx++) begin
                if (m != 1 || xx == xs || xx == xe || yy == ys || yy == ye)
                    exp_q.push_back('{xx, yy, ic});
            end
        end
    endtask

    task automatic kick(input int m, input int ix, input int iy,
                        input int iw, input int ih, input int ic);
        @(negedge clk);
        mode  = 2'(m);
        x0    = XW'(ix);
        y0    = YW'(iy);
        w     = (XW+1)'(iw);
        h     = (YW+1)'(ih);
        color = CD'(ic);
        start = 1'b1;
    endtask

    // Observe one operation; cycle 1 is the sample just after the accepting edge
    task automatic run_op(input int budget, output int np, output int first,
                          output int last, output int dcyc, output int busy_low);
        int cyc;
        cyc = 0; np = 0; first = -1; last = -1; dcyc = -1; busy_low = 0;
        while (dcyc < 0 && cyc < budget) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (plot === 1'b1) begin
                np++;
                if (first < 0) first = cyc;
                last = cyc;
            end
            if (done === 1'b1) dcyc = cyc;
            else if (busy !== 1'b1) busy_low++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; stall = 1'b0; mode = '0;
        x0 = '0; y0 = '0; w = '0; h = '0; color = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({plot, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctrl: got plot/busy/done=%b want 000", {plot, busy, done});
        end
        total++;
        if ({vga_x, vga_y, vga_color} !== '0) begin
            bad++;
            $display("FAIL reset_pixel: got (%0d,%0d,%h) want zeros", vga_x, vga_y, vga_color);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fill();
        int np, first, last, dcyc, bl;
        exp_q.push_back('{10, 20, 'h1C0});
        exp_q.push_back('{11, 20, 'h1C0});
        exp_q.push_back('{12, 20, 'h1C0});
        exp_q.push_back('{10, 21, 'h1C0});
        exp_q.push_back('{11, 21, 'h1C0});
        exp_q.push_back('{12, 21, 'h1C0});
        kick(0, 10, 20, 3, 2, 'h1C0);
        run_op(40, np, first, last, dcyc, bl);
        total++;
        if (np != 6 || first != 3 || last != 8) begin
            bad++;
            $display("FAIL fill_timing: got np=%0d first=%0d last=%0d want 6/3/8", np, first, last);
        end
        total++;
        if (dcyc != 9 || bl != 0) begin
            bad++;
            $display("FAIL fill_done: got done=%0d busy_low=%0d want 9/0", dcyc, bl);
        end
        total++;
        if (busy !== 1'b0 || vga_color !== CD'('h1C0)) begin
            bad++;
            $display("FAIL fill_end: got busy=%b color=%h want 0/1c0", busy, vga_color);
        end
    endtask

    task automatic test_outline();
        int np, first, last, dcyc, bl;
        push_rect(1, 0, 0, 4, 3, 'h03F);
        kick(1, 0, 0, 4, 3, 'h03F);
        run_op(60, np, first, last, dcyc, bl);
        total++;
        if (np != 10 || first != 3 || last != 14 || dcyc != 15) begin
            bad++;
            $display("FAIL outline: got np=%0d first=%0d last=%0d done=%0d want 10/3/14/15",
                     np, first, last, dcyc);
        end
    endtask

    task automatic test_clip();
        int np, first, last, dcyc, bl;
        exp_q.push_back('{158, 119, 'h155});
        exp_q.push_back('{159, 119, 'h155});
        kick(0, 158, 119, 5, 3, 'h155);
        run_op(40, np, first, last, dcyc, bl);
        total++;
        if (np != 2 || dcyc != 5) begin
            bad++;
            $display("FAIL clip: got np=%0d done=%0d want 2/5", np, dcyc);
        end
    endtask

    task automatic test_empty();
        int np, first, last, dcyc, bl;
        kick(0, 10, 10, 0, 5, 'h1FF);
        run_op(20, np, first, last, dcyc, bl);
        total++;
        if (np != 0 || dcyc != 3 || bl != 0) begin
            bad++;
            $display("FAIL empty_w0: got np=%0d done=%0d busy_low=%0d want 0/3/0", np, dcyc, bl);
        end
        kick(0, 200, 10, 4, 4, 'h1FF);
        run_op(20, np, first, last, dcyc, bl);
        total++;
        if (np != 0 || dcyc != 3) begin
            bad++;
            $display("FAIL empty_offscreen: got np=%0d done=%0d want 0/3", np, dcyc);
        end
    endtask

    task automatic test_mode11();
        int np, first, last, dcyc, bl;
        push_rect(3, 30, 40, 2, 1, 'h0A5);
        kick(3, 30, 40, 2, 1, 'h0A5);
        run_op(20, np, first, last, dcyc, bl);
        total++;
        if (np != 2 || dcyc != 5) begin
            bad++;
            $display("FAIL mode11: got np=%0d done=%0d want 2/5", np, dcyc);
        end
    endtask

    task automatic test_clear();
        int np, first, last, dcyc, bl;
        push_rect(2, 7, 7, 1, 1, 'h007);
        kick(2, 7, 7, 1, 1, 'h007);
        run_op(H * V + 50, np, first, last, dcyc, bl);
        total++;
        if (np != H * V || last - first + 1 != H * V || dcyc != last + 1) begin
            bad++;
            $display("FAIL clear: got np=%0d span=%0d done=%0d want %0d/%0d/%0d",
                     np, last - first + 1, dcyc, H * V, H * V, last + 1);
        end
        total++;
        if (vga_x !== XW'(H - 1) || vga_y !== YW'(V - 1)) begin
            bad++;
            $display("FAIL clear_last: got (%0d,%0d) want (%0d,%0d)", vga_x, vga_y, H - 1, V - 1);
        end
    endtask

    task automatic test_stall_and_ignored_start();
        int cyc, np, dcyc, quiet_bad;
        push_rect(0, 10, 20, 3, 2, 'h1C0);
        kick(0, 10, 20, 3, 2, 'h1C0);
        cyc = 0; np = 0; dcyc = -1;
        while (dcyc < 0 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (plot === 1'b1) np++;
            if (done === 1'b1) dcyc = cyc;
            if (cyc >= 4 && cyc <= 6) begin
                total++;
                if (plot !== 1'b0 || vga_x !== XW'(10) || vga_y !== YW'(20)) begin
                    bad++;
                    $display("FAIL stall_hold c%0d: got plot=%b (%0d,%0d) want 0 (10,20)",
                             cyc, plot, vga_x, vga_y);
                end
            end
            if (cyc == 7) begin
                total++;
                if (plot !== 1'b1 || vga_x !== XW'(11) || vga_y !== YW'(20)) begin
                    bad++;
                    $display("FAIL stall_resume: got plot=%b (%0d,%0d) want 1 (11,20)",
                             plot, vga_x, vga_y);
                end
            end
            if (cyc == 3) stall = 1'b1;
            if (cyc == 6) stall = 1'b0;
            if (cyc == 8) begin
                mode = 2'b00; x0 = XW'(50); y0 = YW'(50); w = 9'd1; h = 8'd1;
                start = 1'b1;
            end
        end
        total++;
        if (np != 6 || dcyc != 12) begin
            bad++;
            $display("FAIL stall_count: got np=%0d done=%0d want 6/12", np, dcyc);
        end
        quiet_bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (plot !== 1'b0 || busy !== 1'b0) quiet_bad++;
        end
        total++;
        if (quiet_bad != 0) begin
            bad++;
            $display("FAIL ignored_start: got %0d active cycles after done want 0", quiet_bad);
        end
    endtask

    task automatic test_back_to_back();
        int np, first, last, dcyc, bl;
        push_rect(0, 1, 1, 1, 1, 'h111);
        push_rect(0, 2, 2, 1, 1, 'h122);
        kick(0, 1, 1, 1, 1, 'h111);
        run_op(20, np, first, last, dcyc, bl);
        // Raise the next request on the very cycle done is seen
        mode = 2'b00; x0 = XW'(2); y0 = YW'(2); w = 9'd1; h = 8'd1; color = CD'('h122);
        start = 1'b1;
        run_op(20, np, first, last, dcyc, bl);
        total++;
        if (np != 1 || first != 3 || dcyc != 4) begin
            bad++;
            $display("FAIL back_to_back: got np=%0d first=%0d done=%0d want 1/3/4", np, first, dcyc);
        end
    endtask

    task automatic test_reset_mid_draw();
        int np, first, last, dcyc, bl, done_seen;
        push_rect(0, 20, 30, 10, 10, 'h0F0);
        kick(0, 20, 30, 10, 10, 'h0F0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({plot, busy, done} !== 3'b000) begin
            bad++;
            $display("FAIL async_reset: got plot/busy/done=%b want 000", {plot, busy, done});
        end
        exp_q.delete();
        done_seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done !== 1'b0 || plot !== 1'b0) done_seen++;
        end
        rst_n = 1'b1;
        total++;
        if (done_seen != 0) begin
            bad++;
            $display("FAIL reset_no_done: got %0d active cycles want 0", done_seen);
        end
        push_rect(0, 5, 5, 1, 1, 'h1AB);
        kick(0, 5, 5, 1, 1, 'h1AB);
        run_op(20, np, first, last, dcyc, bl);
        total++;
        if (np != 1 || dcyc != 4) begin
            bad++;
            $display("FAIL post_reset_fill: got np=%0d done=%0d want 1/4", np, dcyc);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_outline();
        test_clip();
        test_empty();
        test_mode11();
        test_stall_and_ignored_start();
        test_back_to_back();
        test_clear();
        test_reset_mid_draw();
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
